// File: rtl/fdc_meas_sequencer.sv
// Gated frequency counter: counts synchronized rising edges of sig_in over a
// power-of-two gate window, latches the count and streams it out as two bytes.
module fdc_meas_sequencer #(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [2:0]       gate_sel,
    input  logic             sig_in,
    input  logic             out_ready,
    output logic             busy,
    output logic             done,
    output logic             ovf,
    output logic [CNT_W-1:0] result,
    output logic [7:0]       out_data,
    output logic             out_valid
);

    generate
        if (CNT_W > 16 || CNT_W < 1) begin : g_bad_cnt_w
            $error("fdc_meas_sequencer: CNT_W must be in 1..16");
        end
        if (SYNC_STAGES < 1) begin : g_bad_sync
            $error("fdc_meas_sequencer: SYNC_STAGES must be at least 1");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARM,
        S_GATE,
        S_LATCH,
        S_OUT_HI,
        S_OUT_LO
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_sync_prev;
    logic                   w_rise;
    logic [CNT_W-1:0]       r_count;
    logic                   r_ovf_int;
    logic [16:0]            r_timer;
    logic [17:0]            w_gate_len;
    logic [16:0]            w_timer_load;
    logic [15:0]            w_res16;

    // MSB of r_sync is the last synchronizer stage
    assign w_rise       = r_sync[SYNC_STAGES-1] & ~r_sync_prev;
    assign w_gate_len   = 18'd1 << (5'd10 + {2'b00, gate_sel});
    assign w_timer_load = 17'(w_gate_len - 18'd1);

    always_comb begin
        w_res16              = '0;
        w_res16[CNT_W-1:0]   = result;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync      <= '0;
            r_sync_prev <= 1'b0;
        end else begin
            r_sync      <= (r_sync << 1) | SYNC_STAGES'(sig_in);
            r_sync_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Timer is loaded with length-1 in ARM so GATE lasts exactly the gate length
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count   <= '0;
            r_ovf_int <= 1'b0;
            r_timer   <= '0;
            result    <= '0;
            ovf       <= 1'b0;
        end else begin
            case (r_state)
                S_ARM: begin
                    r_count   <= '0;
                    r_ovf_int <= 1'b0;
                    r_timer   <= w_timer_load;
                end
                S_GATE: begin
                    if (w_rise) begin
                        if (r_count == '1) begin
                            r_ovf_int <= 1'b1;
                        end else begin
                            r_count <= r_count + CNT_W'(1);
                        end
                    end
                    if (r_timer != '0) begin
                        r_timer <= r_timer - 17'd1;
                    end
                end
                S_LATCH: begin
                    result <= r_count;
                    ovf    <= r_ovf_int;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next    = r_state;
        busy      = (r_state != S_IDLE);
        done      = 1'b0;
        out_valid = 1'b0;
        out_data  = '0;
        case (r_state)
            S_IDLE:  if (start) w_next = S_ARM;
            S_ARM:   w_next = S_GATE;
            S_GATE:  if (r_timer == '0) w_next = S_LATCH;
            S_LATCH: w_next = S_OUT_HI;
            S_OUT_HI: begin
                out_valid = 1'b1;
                out_data  = w_res16[15:8];
                if (out_ready) w_next = S_OUT_LO;
            end
            S_OUT_LO: begin
                out_valid = 1'b1;
                out_data  = w_res16[7:0];
                if (out_ready) begin
                    w_next = S_IDLE;
                    done   = ~abort;
                end
            end
            default: w_next = S_IDLE;
        endcase
        if (abort && r_state != S_IDLE) begin
            w_next = S_IDLE;
        end
    end

endmodule

// File: tb/tb_fdc_meas_sequencer.sv
// Directed bench for fdc_meas_sequencer: a 16-bit instance plus a 10-bit
// instance (sharing inputs) used to reach saturation in a short gate.
module tb_fdc_meas_sequencer;

    logic        clk = 1'b0;
    logic        rst, start, abort, sig_in, out_ready;
    logic [2:0]  gate_sel;
    logic        busy, done, ovf, out_valid;
    logic [15:0] result;
    logic [7:0]  out_data;
    logic        busy_b, done_b, ovf_b, out_valid_b;
    logic [9:0]  result_b;
    logic [7:0]  out_data_b;

    int vectors     = 0;
    int miscompares = 0;
    int sig_mode    = 0;
    logic [7:0] b2_hi, b2_lo;

    fdc_meas_sequencer #(.CNT_W(16), .SYNC_STAGES(2)) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .gate_sel(gate_sel),
        .sig_in(sig_in), .out_ready(out_ready), .busy(busy), .done(done), .ovf(ovf),
        .result(result), .out_data(out_data), .out_valid(out_valid)
    );

    fdc_meas_sequencer #(.CNT_W(10), .SYNC_STAGES(3)) u_dut10 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .gate_sel(gate_sel),
        .sig_in(sig_in), .out_ready(out_ready), .busy(busy_b), .done(done_b), .ovf(ovf_b),
        .result(result_b), .out_data(out_data_b), .out_valid(out_valid_b)
    );

    always #5 clk = ~clk;

    // sig_mode: 0 low, 1 high, 2 period-2 toggle, 3 period-16 square wave
    initial begin
        int ph;
        ph = 0;
        sig_in = 1'b0;
        forever begin
            @(negedge clk);
            case (sig_mode)
                0: sig_in = 1'b0;
                1: sig_in = 1'b1;
                2: sig_in = ~sig_in;
                default: begin
                    ph = ph + 1;
                    sig_in = ph[3];
                end
            endcase
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_valid(input string tag);
        int k;
        k = 0;
        while (out_valid !== 1'b1 && k < 5000) begin
            step();
            k++;
        end
        chk(tag, {31'd0, out_valid}, 32'd1);
    endtask

    task automatic measure(input logic [2:0] gs, input logic [2:0] gs_late, input int exp_n,
                           input logic [15:0] exp_res, input logic exp_ovf, input string tag);
        int n, nv, nv2, dn;
        logic [7:0] b_hi, b_lo;
        n = 0; nv = 0; nv2 = 0; dn = 0;
        b_hi = '0; b_lo = '0;
        out_ready = 1'b1;
        gate_sel = gs;
        start = 1'b1;
        step();
        start = 1'b0;
        while (busy === 1'b1 && n < 20000) begin
            if (n == 100) gate_sel = gs_late;
            if (out_valid === 1'b1) begin
                if (nv == 0) b_hi = out_data; else b_lo = out_data;
                nv++;
            end
            if (out_valid_b === 1'b1) begin
                if (nv2 == 0) b2_hi = out_data_b; else b2_lo = out_data_b;
                nv2++;
            end
            if (done === 1'b1) dn++;
            n++;
            step();
        end
        chk({tag, "_busy_cycles"}, n, exp_n);
        chk({tag, "_done_pulses"}, dn, 1);
        chk({tag, "_valid_beats"}, nv, 2);
        chk({tag, "_byte_hi"}, b_hi, exp_res[15:8]);
        chk({tag, "_byte_lo"}, b_lo, exp_res[7:0]);
        chk({tag, "_result"}, result, exp_res);
        chk({tag, "_ovf"}, ovf, exp_ovf);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; abort = 1'b0; out_ready = 1'b1; gate_sel = 3'd0;
        sig_mode = 1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_result", result, 0);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        #3 rst = 1'b0;
        repeat (8) step();
        chk("post_rst_busy", busy, 0);
        chk("post_rst_done", done, 0);
        chk("post_rst_result", result, 0);

        // Period-16 wave over a 1024-cycle gate
        sig_mode = 3;
        repeat (20) step();
        measure(3'd0, 3'd0, 1028, 16'h0040, 1'b0, "p16_gs0");
        chk("p16_gs0_result10", result_b, 10'd64);

        // Constant-high input: no edges, 8192-cycle gate
        sig_mode = 1;
        repeat (10) step();
        measure(3'd3, 3'd3, 8196, 16'h0000, 1'b0, "held1_gs3");

        // Period-2 wave: 1024 edges; 10-bit instance saturates
        sig_mode = 2;
        repeat (10) step();
        measure(3'd1, 3'd1, 2052, 16'h0400, 1'b0, "p2_gs1");
        chk("p2_sat10_result", result_b, 10'h3FF);
        chk("p2_sat10_ovf", ovf_b, 1);
        chk("p2_sat10_byte_hi", b2_hi, 8'h03);
        chk("p2_sat10_byte_lo", b2_lo, 8'hFF);

        // Back-pressure in OUT_HI: 512 edges -> 0x0200
        out_ready = 1'b0;
        gate_sel = 3'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_valid("stall_reach_hi");
        for (int i = 0; i < 10; i++) begin
            chk("stall_hi_hold", {23'd0, out_valid, out_data}, 32'h102);
            chk("stall_no_done", done, 0);
            step();
        end
        out_ready = 1'b1;
        step();
        chk("stall_lo_byte", {23'd0, out_valid, out_data}, 32'h100);
        chk("stall_done", done, 1);
        step();
        chk("stall_idle_busy", busy, 0);
        chk("stall_idle_done", done, 0);
        chk("stall_result", result, 16'h0200);

        // Abort in GATE cycle 500, then a fresh measurement
        sig_mode = 3;
        repeat (10) step();
        gate_sel = 3'd0;
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        repeat (499) step();
        chk("abort_in_gate_busy", busy, 1);
        abort = 1'b1;
        #1;
        chk("abort_no_done", done, 0);
        step();
        abort = 1'b0;
        chk("abort_idle_busy", busy, 0);
        chk("abort_idle_done", done, 0);
        chk("abort_result_kept", result, 16'h0200);
        measure(3'd0, 3'd0, 1028, 16'h0040, 1'b0, "after_abort");

        // Abort and out_ready together in OUT_LO: abort wins
        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_valid("abortlo_reach_hi");
        out_ready = 1'b1;
        step();
        chk("abortlo_in_lo", {23'd0, out_valid, out_data}, 32'h140);
        abort = 1'b1;
        #1;
        chk("abortlo_no_done", done, 0);
        step();
        abort = 1'b0;
        chk("abortlo_idle_busy", busy, 0);
        chk("abortlo_result", result, 16'h0040);

        // Asynchronous reset while in OUT_LO
        out_ready = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        wait_valid("rstlo_reach_hi");
        out_ready = 1'b1;
        step();
        chk("rstlo_done_before", done, 1);
        #2 rst = 1'b1;
        #1;
        chk("rstlo_busy", busy, 0);
        chk("rstlo_done", done, 0);
        chk("rstlo_out_valid", out_valid, 0);
        chk("rstlo_out_data", out_data, 0);
        chk("rstlo_result", result, 0);
        chk("rstlo_ovf", ovf, 0);
        #3 rst = 1'b0;
        repeat (4) step();
        chk("rstlo_post_busy", busy, 0);

        // gate_sel changed mid-GATE must not alter the captured length
        measure(3'd0, 3'd7, 1028, 16'h0040, 1'b0, "gsel_change");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
